// File: rtl/exe_muldiv_unit_pkg.sv
// exe_muldiv_unit_pkg: shared definitions for the EXE-stage multiply/divide unit.
//   - default operand width and iteration counter width
//   - op codes carried on the op bus
//   - FSM state encoding
//   - helper to classify signed operations
package exe_muldiv_unit_pkg;

    localparam int unsigned MdWidth = 32;
    localparam int unsigned MdCntW  = 5;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// exe_muldiv_unit_if: request/result bundle between EXE control and the mul/div unit.
//   start, op, a, b, flush : requester -> unit
//   busy, done, hi, lo     : unit -> requester / hazard logic
// master modport is the EXE side, slave modport is the unit.
interface exe_muldiv_unit_if
    import exe_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/exe_muldiv_unit_iter_core.sv
// exe_muldiv_unit_iter_core: radix-2 iterative datapath for the mul/div unit.
// Operands arrive as unsigned magnitudes; sign handling lives in the parent.
//   clk, rst_n      : clock, async active-low reset
//   load_i          : capture a_mag_i/b_mag_i and clear the counter
//   step_i          : perform one iteration
//   is_div_i        : selects shift-subtract (1) or shift-add (0) for step_i
//   a_mag_i/b_mag_i : multiplier/dividend and multiplicand/divisor magnitudes
//   prod_o          : 2*WIDTH product
//   quo_o/rem_o     : quotient / remainder
//   last_o          : the current step is the final one
module exe_muldiv_unit_iter_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_mag_i,
    input  logic [WIDTH-1:0]   b_mag_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic               last_o
);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    always_comb begin
        prod_d = prod_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        opb_d  = opb_q;
        cnt_d  = cnt_q;

        // Multiplier sits in the low half and is consumed LSB first; the
        // carry out of the upper-half add shifts down into the product.
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        // Partial remainder stays below the divisor, so WIDTH bits hold it
        // and one extra bit is enough for the trial subtract.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};

        if (load_i) begin
            prod_d = {{WIDTH{1'b0}}, a_mag_i};
            quo_d  = a_mag_i;
            rem_d  = '0;
            opb_d  = b_mag_i;
            cnt_d  = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_i) begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            prod_q <= prod_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign prod_o = prod_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: EXE-stage iterative multiply/divide unit owning HI/LO.
//   clk, rst_n : clock, async active-low reset
//   mdu_io     : slave side of exe_muldiv_unit_if
//                start/op/a/b/flush in; busy (stall), done (1-cycle pulse), hi, lo out
// MULT/MULTU/DIV/DIVU run IDLE -> CALC (WIDTH steps) -> FIX (sign fixup, HI/LO write).
// MTHI/MTLO write HI/LO at the accept edge without leaving IDLE.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete combinationally at
// the accept edge (no busy), divides keep the iterative path.
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth,
    parameter int unsigned CNT_W = MdCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    exe_muldiv_unit_if.slave mdu_io
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;

    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               latch;

    logic               core_load, core_step, core_last;
    logic [2*WIDTH-1:0] core_prod, prod_fix;
    logic [WIDTH-1:0]   core_quo, core_rem, quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
`endif

    // Operand magnitudes. Negating 2^(WIDTH-1) wraps to itself, which is the
    // correct unsigned magnitude, so no extra bit needs to reach the core.
    always_comb begin
        signed_op = is_signed_op(mdu_io.op);
        a_neg     = signed_op & mdu_io.a[WIDTH-1];
        b_neg     = signed_op & mdu_io.b[WIDTH-1];
        a_mag     = a_neg ? ('0 - mdu_io.a) : mdu_io.a;
        b_mag     = b_neg ? ('0 - mdu_io.b) : mdu_io.b;
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        ext_a     = {{WIDTH{a_neg}}, mdu_io.a};
        ext_b     = {{WIDTH{b_neg}}, mdu_io.b};
        fast_prod = ext_a * ext_b;
    end
`endif

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = neg_res_q ? ('0 - core_prod) : core_prod;
        // Divide by zero leaves an all-ones quotient regardless of signs.
        quo_fix  = div0_q ? '1 : (neg_res_q ? ('0 - core_quo) : core_quo);
        rem_fix  = neg_rem_q ? ('0 - core_rem) : core_rem;
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        latch     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mdu_io.start) begin
                    unique case (mdu_io.op)
                        OpMult, OpMultu: begin
`ifdef MULDIV_FAST_MUL_EN
                            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d   = fast_prod[WIDTH-1:0];
                            done_d = 1'b1;
`else
                            core_load = 1'b1;
                            latch     = 1'b1;
                            state_d   = StCalc;
`endif
                        end
                        OpDiv, OpDivu: begin
                            core_load = 1'b1;
                            latch     = 1'b1;
                            state_d   = StCalc;
                        end
                        OpMthi:  hi_d = mdu_io.a;
                        OpMtlo:  lo_d = mdu_io.a;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything, including a same-cycle start.
        if (mdu_io.flush) begin
            state_d   = StIdle;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            core_load = 1'b0;
            core_step = 1'b0;
            latch     = 1'b0;
        end
    end

    always_comb begin
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        if (latch) begin
            is_div_d  = (mdu_io.op == OpDiv) || (mdu_io.op == OpDivu);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = (mdu_io.b == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    exe_muldiv_unit_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (is_div_q),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .prod_o   (core_prod),
        .quo_o    (core_quo),
        .rem_o    (core_rem),
        .last_o   (core_last)
    );

    assign mdu_io.busy = (state_q != StIdle);
    assign mdu_io.done = done_q;
    assign mdu_io.hi   = hi_q;
    assign mdu_io.lo   = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit (default build, iterative multiply).
module tb_exe_muldiv_unit;
    import exe_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_muldiv_unit_if #(.WIDTH(32)) mdu_if ();

    exe_muldiv_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdu_io (mdu_if)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        string nm;
        if (rst_n && mdu_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending result");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, {mdu_if.hi, mdu_if.lo}, e);
            end
        end
    end

    // Issue a mul/div, push its expected {hi,lo}, then check latency, the
    // done pulse and that hi/lo hold during CALC. poke drives a stray MTHI
    // mid-operation, which must be ignored.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit poke);
        logic [63:0] held;
        int n;
        bit held_ok;
        bit seen;
        exp_q.push_back({ehi, elo});
        name_q.push_back(name);
        @(negedge clk);
        held = {mdu_if.hi, mdu_if.lo};
        mdu_if.start = 1'b1;
        mdu_if.op    = op;
        mdu_if.a     = a;
        mdu_if.b     = b;
        @(posedge clk);
        #1 mdu_if.start = 1'b0;
        n = 0;
        held_ok = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mdu_if.busy) begin
                n++;
                if ({mdu_if.hi, mdu_if.lo} !== held) held_ok = 1'b0;
                if (poke && n == 3) begin
                    mdu_if.start = 1'b1;
                    mdu_if.op    = OpMthi;
                    mdu_if.a     = 32'hDEAD_BEEF;
                end else begin
                    mdu_if.start = 1'b0;
                end
            end else begin
                seen = 1'b1;
                break;
            end
        end
        mdu_if.start = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy stuck want idle within 100 cycles", name);
        end else begin
            check({name, "_busy_cycles"}, 64'(n), 64'd33);
            check({name, "_done"}, 64'(mdu_if.done), 64'd1);
            check({name, "_hold"}, 64'(held_ok), 64'd1);
        end
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(mdu_if.done), 64'd0);
    endtask

    // Single-cycle IDLE request (MTHI/MTLO/no-op), optionally with flush.
    task automatic idle_req(input logic [2:0] op, input logic [31:0] a, input logic fl);
        @(negedge clk);
        mdu_if.start = 1'b1;
        mdu_if.flush = fl;
        mdu_if.op    = op;
        mdu_if.a     = a;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
        mdu_if.flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int dones;
        mdu_if.start = 1'b0;
        mdu_if.flush = 1'b0;
        mdu_if.op    = 3'b111;
        mdu_if.a     = '0;
        mdu_if.b     = '0;

        #12;
        check("rst_busy", 64'(mdu_if.busy), 64'd0);
        check("rst_done", 64'(mdu_if.done), 64'd0);
        check("rst_hilo", {mdu_if.hi, mdu_if.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_neg",   OpMult,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu",      OpMultu, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1);
        run_op("mult_min",   OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_neg",    OpDiv,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negb",   OpDiv,   32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
        run_op("divu_zero",  OpDivu,  32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero",   OpDiv,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf",    OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

        // MTHI / MTLO / no-op in IDLE
        idle_req(OpMthi, 32'h1234_5678, 1'b0);
        check("mthi_hi", 64'(mdu_if.hi), 64'h1234_5678);
        check("mthi_lo", 64'(mdu_if.lo), 64'h8000_0000);
        check("mthi_busy", 64'(mdu_if.busy), 64'd0);
        check("mthi_done", 64'(mdu_if.done), 64'd0);
        idle_req(OpMtlo, 32'hCAFE_F00D, 1'b0);
        check("mtlo", {mdu_if.hi, mdu_if.lo}, 64'h1234_5678_CAFE_F00D);
        idle_req(3'b110, 32'h5555_5555, 1'b0);
        check("noop_hilo", {mdu_if.hi, mdu_if.lo}, 64'h1234_5678_CAFE_F00D);
        check("noop_busy", 64'(mdu_if.busy), 64'd0);
        idle_req(OpMthi, 32'hAAAA_AAAA, 1'b1);
        check("flush_mthi", {mdu_if.hi, mdu_if.lo}, 64'h1234_5678_CAFE_F00D);

        // Flush mid-divide
        @(negedge clk);
        mdu_if.start = 1'b1;
        mdu_if.op    = OpDivu;
        mdu_if.a     = 32'd1000;
        mdu_if.b     = 32'd3;
        @(posedge clk);
        #1 mdu_if.start = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("flush_busy_before", 64'(mdu_if.busy), 64'd1);
        mdu_if.flush = 1'b1;
        @(negedge clk);
        mdu_if.flush = 1'b0;
        check("flush_busy_after", 64'(mdu_if.busy), 64'd0);
        check("flush_hilo", {mdu_if.hi, mdu_if.lo}, 64'h1234_5678_CAFE_F00D);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);

        run_op("divu_after_flush", OpDivu, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        mdu_if.start = 1'b1;
        mdu_if.op    = OpMult;
        mdu_if.a     = 32'd5;
        mdu_if.b     = 32'd7;
        @(posedge clk);
        #1 mdu_if.start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(mdu_if.busy), 64'd0);
        check("arst_hilo", {mdu_if.hi, mdu_if.lo}, 64'd0);
        check("arst_done", 64'(mdu_if.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu_if.done === 1'b1) dones++;
        end
        check("arst_no_done", 64'(dones), 64'd0);
        check("arst_idle_hilo", {mdu_if.hi, mdu_if.lo}, 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
